softex_fp_lane_packer: RTL and testbench

- Assembles a scalar FP element stream into N_OUT-lane vectors with per-lane strobes and a tag.
- Its output is exactly the input side of the softex recursive FP adder tree: valid/ready, op vector, strb vector, tag.
- Sits between the softex streamer/normaliser and the adder reduction. Handles partial final vectors: unused lanes are zero and their strobes are cleared.

---
 rtl/softex_fp_lane_packer_if.sv | 42 ++++
 rtl/softex_fp_lane_packer.sv | 153 +++++++++++++++
 tb/tb_softex_fp_lane_packer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/softex_fp_lane_packer_if.sv
// softex_fp_lane_packer_if
//   Bundles the element-stream input, the vector-stream output and the flush/busy
//   sideband of softex_fp_lane_packer.
//   slave  : packer side (consumes elements, produces vectors).
//   master : environment side (streamer upstream plus adder tree downstream).
// Signals:
//   clear_i          synchronous flush
//   valid_i/ready_o  element handshake, data_i element, last_i closes vector,
//                    tag_i sampled on lane-0 element
//   valid_o/ready_i  vector handshake, op_o lanes, strb_o lane mask, tag_o, last_o
//   busy_o           partial vector or pending output held
interface softex_fp_lane_packer_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_OUT    = 8,
  parameter type         TAG_TYPE = logic
) ();

  logic                        clear_i;
  logic                        valid_i;
  logic                        ready_o;
  logic [WIDTH-1:0]            data_i;
  logic                        last_i;
  TAG_TYPE                     tag_i;
  logic                        valid_o;
  logic                        ready_i;
  logic [N_OUT-1:0][WIDTH-1:0] op_o;
  logic [N_OUT-1:0]            strb_o;
  TAG_TYPE                     tag_o;
  logic                        last_o;
  logic                        busy_o;

  modport slave (
    input  clear_i, valid_i, data_i, last_i, tag_i, ready_i,
    output ready_o, valid_o, op_o, strb_o, tag_o, last_o, busy_o
  );

  modport master (
    output clear_i, valid_i, data_i, last_i, tag_i, ready_i,
    input  ready_o, valid_o, op_o, strb_o, tag_o, last_o, busy_o
  );

endinterface

// File: rtl/softex_fp_lane_packer.sv
// softex_fp_lane_packer
//   Packs a scalar FP element stream into N_OUT-lane vectors with a per-lane strobe
//   mask and a per-vector tag, feeding the input of the softex FP adder tree.
//   A vector closes on its N_OUT-th element or on an element flagged last_i; unused
//   lanes of a partial vector are zero with their strobes cleared.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     softex_fp_lane_packer_if.slave (element in, vector out, clear, busy)
module softex_fp_lane_packer #(
  parameter int unsigned FPFORMAT     = 0,  // 0 FP32, 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
  parameter int unsigned FPFORMAT_ACC = 0,
  parameter int unsigned N_OUT        = 8,
  parameter type         TAG_TYPE     = logic
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  softex_fp_lane_packer_if.slave  bus
);

  // Same encoding order as the fpnew format enumeration.
  function automatic int unsigned fp_width(input int unsigned fmt);
    case (fmt)
      0:       fp_width = 32;
      1:       fp_width = 64;
      2:       fp_width = 16;
      3:       fp_width = 8;
      4:       fp_width = 16;
      default: fp_width = 32;
    endcase
  endfunction

  localparam int unsigned WIDTH = fp_width(FPFORMAT);
  localparam int unsigned CntW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(N_OUT - 1);

  // The downstream accumulator must hold at least an element.
  if (fp_width(FPFORMAT_ACC) < WIDTH) begin : gen_acc_width_check
    $error("FPFORMAT_ACC is narrower than FPFORMAT");
  end

  typedef logic [N_OUT-1:0][WIDTH-1:0] lanes_t;

  // Assembly buffer
  lanes_t           r_asm, w_asm_nxt;
  logic [N_OUT-1:0] r_asm_strb, w_asm_strb_nxt;
  logic [CntW-1:0]  r_cnt, w_cnt_nxt;
  TAG_TYPE          r_asm_tag, w_asm_tag_nxt;

  // Output register
  logic             r_out_valid, w_out_valid_nxt;
  lanes_t           r_out_op, w_out_op_nxt;
  logic [N_OUT-1:0] r_out_strb, w_out_strb_nxt;
  TAG_TYPE          r_out_tag, w_out_tag_nxt;
  logic             r_out_last, w_out_last_nxt;

  logic             w_ready;
  logic             w_accept;
  logic             w_close;
  lanes_t           w_asm_ins;
  logic [N_OUT-1:0] w_strb_ins;
  TAG_TYPE          w_tag_ins;

  // The output slot frees up in the same cycle it drains, so ready_i feeds ready_o.
  assign w_ready  = ~r_out_valid | bus.ready_i;
  assign w_accept = bus.valid_i & w_ready;
  assign w_close  = w_accept & ((r_cnt == LastLane) | bus.last_i);

  // Assembly buffer with the incoming element merged in; a closing element is
  // forwarded straight into the output register from here.
  always_comb begin
    w_asm_ins          = r_asm;
    w_asm_ins[r_cnt]   = bus.data_i;
    w_strb_ins         = r_asm_strb;
    w_strb_ins[r_cnt]  = 1'b1;
    w_tag_ins          = (r_cnt == '0) ? bus.tag_i : r_asm_tag;
  end

  always_comb begin
    w_asm_nxt       = r_asm;
    w_asm_strb_nxt  = r_asm_strb;
    w_cnt_nxt       = r_cnt;
    w_asm_tag_nxt   = r_asm_tag;
    w_out_valid_nxt = r_out_valid;
    w_out_op_nxt    = r_out_op;
    w_out_strb_nxt  = r_out_strb;
    w_out_tag_nxt   = r_out_tag;
    w_out_last_nxt  = r_out_last;

    if (bus.clear_i) begin
      // Flush wins over any simultaneous accept or close.
      w_asm_nxt       = '0;
      w_asm_strb_nxt  = '0;
      w_cnt_nxt       = '0;
      w_asm_tag_nxt   = '0;
      w_out_valid_nxt = 1'b0;
    end else begin
      if (r_out_valid && bus.ready_i) begin
        w_out_valid_nxt = 1'b0;
      end
      if (w_close) begin
        // Overrides the drain above: a simultaneous drain and close reloads.
        w_out_valid_nxt = 1'b1;
        w_out_op_nxt    = w_asm_ins;
        w_out_strb_nxt  = w_strb_ins;
        w_out_tag_nxt   = w_tag_ins;
        w_out_last_nxt  = bus.last_i;
        w_asm_nxt       = '0;
        w_asm_strb_nxt  = '0;
        w_cnt_nxt       = '0;
        w_asm_tag_nxt   = '0;
      end else if (w_accept) begin
        w_asm_nxt      = w_asm_ins;
        w_asm_strb_nxt = w_strb_ins;
        w_asm_tag_nxt  = w_tag_ins;
        w_cnt_nxt      = r_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_asm       <= '0;
      r_asm_strb  <= '0;
      r_cnt       <= '0;
      r_asm_tag   <= '0;
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_strb  <= '0;
      r_out_tag   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_asm       <= w_asm_nxt;
      r_asm_strb  <= w_asm_strb_nxt;
      r_cnt       <= w_cnt_nxt;
      r_asm_tag   <= w_asm_tag_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_op    <= w_out_op_nxt;
      r_out_strb  <= w_out_strb_nxt;
      r_out_tag   <= w_out_tag_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_out_valid;
  assign bus.op_o    = r_out_op;
  assign bus.strb_o  = r_out_strb;
  assign bus.tag_o   = r_out_tag;
  assign bus.last_o  = r_out_last;
  assign bus.busy_o  = (r_cnt != '0) | r_out_valid;

endmodule

// File: tb/tb_softex_fp_lane_packer.sv
// Directed bench for softex_fp_lane_packer, FP32 with four lanes and a 4-bit tag.
module tb_softex_fp_lane_packer;

  typedef logic [3:0]       tag_t;
  typedef logic [3:0][31:0] vec_t;

  logic clk;
  logic rst_ni;
  int   n_cmp;
  int   n_err;

  softex_fp_lane_packer_if #(.WIDTH(32), .N_OUT(4), .TAG_TYPE(tag_t)) bus ();

  softex_fp_lane_packer #(
    .FPFORMAT    (0),
    .FPFORMAT_ACC(0),
    .N_OUT       (4),
    .TAG_TYPE    (tag_t)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_ni),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.data_i  = '0;
    bus.last_i  = 1'b0;
    bus.tag_i   = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input tag_t t, input logic l);
    bus.valid_i = 1'b1;
    bus.data_i  = d;
    bus.tag_i   = t;
    bus.last_i  = l;
    cycle();
  endtask

  task automatic test_reset();
    rst_ni      = 1'b0;
    bus.clear_i = 1'b0;
    bus.ready_i = 1'b0;
    idle();
    #2;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.op_o !== '0) begin n_err++; $display("FAIL rst_op: got %h want 0", bus.op_o); end
    n_cmp++; if (bus.strb_o !== 4'b0000) begin n_err++; $display("FAIL rst_strb: got %b want 0000", bus.strb_o); end
    n_cmp++; if (bus.tag_o !== 4'd0) begin n_err++; $display("FAIL rst_tag: got %0d want 0", bus.tag_o); end
    n_cmp++; if (bus.last_o !== 1'b0) begin n_err++; $display("FAIL rst_last: got %b want 0", bus.last_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", bus.ready_o); end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    cycle();
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b want 1", bus.ready_o); end
  endtask

  task automatic test_full_vector();
    vec_t want;
    want[0] = 32'h3F80_0000; want[1] = 32'h4000_0000;
    want[2] = 32'h4040_0000; want[3] = 32'h4080_0000;
    bus.ready_i = 1'b1;
    send(want[0], 4'd5, 1'b0);
    send(want[1], 4'd0, 1'b0);
    send(want[2], 4'd0, 1'b0);
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL full_early_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL full_fill_busy: got %b want 1", bus.busy_o); end
    send(want[3], 4'd0, 1'b0);
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL full_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL full_op: got %h want %h", bus.op_o, want); end
    n_cmp++; if (bus.strb_o !== 4'b1111) begin n_err++; $display("FAIL full_strb: got %b want 1111", bus.strb_o); end
    n_cmp++; if (bus.tag_o !== 4'd5) begin n_err++; $display("FAIL full_tag: got %0d want 5", bus.tag_o); end
    n_cmp++; if (bus.last_o !== 1'b0) begin n_err++; $display("FAIL full_last: got %b want 0", bus.last_o); end
    cycle();
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL full_drain_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL full_drain_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_partial();
    vec_t want;
    want[0] = 32'h3F80_0000; want[1] = 32'h4000_0000;
    want[2] = 32'h4040_0000; want[3] = 32'h0000_0000;
    bus.ready_i = 1'b1;
    send(want[0], 4'd7, 1'b0);
    send(want[1], 4'd0, 1'b0);
    send(want[2], 4'd0, 1'b1);
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL part_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL part_op: got %h want %h", bus.op_o, want); end
    n_cmp++; if (bus.strb_o !== 4'b0111) begin n_err++; $display("FAIL part_strb: got %b want 0111", bus.strb_o); end
    n_cmp++; if (bus.last_o !== 1'b1) begin n_err++; $display("FAIL part_last: got %b want 1", bus.last_o); end
    n_cmp++; if (bus.tag_o !== 4'd7) begin n_err++; $display("FAIL part_tag: got %0d want 7", bus.tag_o); end
    // Next element drains the previous vector and closes alone in lane 0.
    want = '0;
    want[0] = 32'h40A0_0000;
    send(want[0], 4'd9, 1'b1);
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL reload_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL reload_op: got %h want %h", bus.op_o, want); end
    n_cmp++; if (bus.strb_o !== 4'b0001) begin n_err++; $display("FAIL reload_strb: got %b want 0001", bus.strb_o); end
    n_cmp++; if (bus.tag_o !== 4'd9) begin n_err++; $display("FAIL reload_tag: got %0d want 9", bus.tag_o); end
    cycle();
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL part_drain_valid: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_backpressure();
    vec_t wa;
    vec_t wb;
    wa[0] = 32'h4100_0000; wa[1] = 32'h4110_0000; wa[2] = 32'h4120_0000; wa[3] = 32'h4130_0000;
    wb[0] = 32'h4140_0000; wb[1] = 32'h4150_0000; wb[2] = 32'h4160_0000; wb[3] = 32'h4170_0000;
    bus.ready_i = 1'b1;
    send(wa[0], 4'd3, 1'b0);
    send(wa[1], 4'd0, 1'b0);
    send(wa[2], 4'd0, 1'b0);
    send(wa[3], 4'd0, 1'b0);
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.data_i  = wb[0];
    bus.tag_i   = 4'd11;
    bus.last_i  = 1'b0;
    #1;
    n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", bus.ready_o); end
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, bus.valid_o); end
      n_cmp++; if (bus.op_o !== wa) begin n_err++; $display("FAIL bp_hold_op[%0d]: got %h want %h", i, bus.op_o, wa); end
      n_cmp++; if (bus.strb_o !== 4'b1111) begin n_err++; $display("FAIL bp_hold_strb[%0d]: got %b want 1111", i, bus.strb_o); end
      n_cmp++; if (bus.tag_o !== 4'd3) begin n_err++; $display("FAIL bp_hold_tag[%0d]: got %0d want 3", i, bus.tag_o); end
      n_cmp++; if (bus.last_o !== 1'b0) begin n_err++; $display("FAIL bp_hold_last[%0d]: got %b want 0", i, bus.last_o); end
      n_cmp++; if (bus.ready_o !== 1'b0) begin n_err++; $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, bus.ready_o); end
    end
    bus.ready_i = 1'b1;
    send(wb[0], 4'd11, 1'b0);
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_drain_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_err++; $display("FAIL bp_drain_busy: got %b want 1", bus.busy_o); end
    send(wb[1], 4'd0, 1'b0);
    send(wb[2], 4'd0, 1'b0);
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL bp_b_early_valid: got %b want 0", bus.valid_o); end
    send(wb[3], 4'd0, 1'b0);
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL bp_b_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.op_o !== wb) begin n_err++; $display("FAIL bp_b_op: got %h want %h", bus.op_o, wb); end
    n_cmp++; if (bus.tag_o !== 4'd11) begin n_err++; $display("FAIL bp_b_tag: got %0d want 11", bus.tag_o); end
    cycle();
  endtask

  task automatic test_flush();
    vec_t want;
    want[0] = 32'h4230_0000; want[1] = 32'h4240_0000; want[2] = 32'h4250_0000; want[3] = 32'h4260_0000;
    bus.ready_i = 1'b1;
    send(32'h4200_0000, 4'd1, 1'b0);
    send(32'h4210_0000, 4'd0, 1'b0);
    bus.valid_i = 1'b1;
    bus.data_i  = 32'h4220_0000;
    bus.clear_i = 1'b1;
    #1;
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", bus.ready_o); end
    cycle();
    bus.clear_i = 1'b0;
    idle();
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL flush_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", bus.valid_o); end
    send(want[0], 4'd2, 1'b0);
    send(want[1], 4'd0, 1'b0);
    send(want[2], 4'd0, 1'b0);
    send(want[3], 4'd0, 1'b0);
    idle();
    n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL flush_op: got %h want %h", bus.op_o, want); end
    n_cmp++; if (bus.strb_o !== 4'b1111) begin n_err++; $display("FAIL flush_strb: got %b want 1111", bus.strb_o); end
    n_cmp++; if (bus.tag_o !== 4'd2) begin n_err++; $display("FAIL flush_tag: got %0d want 2", bus.tag_o); end
    cycle();
  endtask

  task automatic test_back_to_back_singles();
    vec_t want;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      want    = '0;
      want[0] = 32'h4300_0000 + 32'(i);
      send(want[0], tag_t'(i), 1'b1);
      n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid[%0d]: got %b want 1", i, bus.valid_o); end
      n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL single_op[%0d]: got %h want %h", i, bus.op_o, want); end
      n_cmp++; if (bus.strb_o !== 4'b0001) begin n_err++; $display("FAIL single_strb[%0d]: got %b want 0001", i, bus.strb_o); end
      n_cmp++; if (bus.last_o !== 1'b1) begin n_err++; $display("FAIL single_last[%0d]: got %b want 1", i, bus.last_o); end
      n_cmp++; if (bus.tag_o !== tag_t'(i)) begin n_err++; $display("FAIL single_tag[%0d]: got %0d want %0d", i, bus.tag_o, i); end
    end
    idle();
    cycle();
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL single_drain_valid: got %b want 0", bus.valid_o); end
  endtask

  task automatic test_reset_mid_fill();
    vec_t want;
    want[0] = 32'h4600_0000; want[1] = 32'h4610_0000; want[2] = 32'h4620_0000; want[3] = 32'h4630_0000;
    // Pending output vector held under backpressure.
    bus.ready_i = 1'b1;
    send(32'h4400_0000, 4'd6, 1'b0);
    send(32'h4410_0000, 4'd0, 1'b0);
    send(32'h4420_0000, 4'd0, 1'b1);
    bus.ready_i = 1'b0;
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL mid_pend_valid: got %b want 1", bus.valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", bus.valid_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b want 1", bus.ready_o); end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    cycle();
    // Partial fill lost to reset.
    bus.ready_i = 1'b1;
    send(32'h4500_0000, 4'd4, 1'b0);
    send(32'h4510_0000, 4'd0, 1'b0);
    idle();
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_err++; $display("FAIL mid_fill_busy: got %b want 0", bus.busy_o); end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    cycle();
    send(want[0], 4'd8, 1'b0);
    send(want[1], 4'd0, 1'b0);
    send(want[2], 4'd0, 1'b0);
    send(want[3], 4'd0, 1'b0);
    idle();
    n_cmp++; if (bus.valid_o !== 1'b1) begin n_err++; $display("FAIL mid_after_valid: got %b want 1", bus.valid_o); end
    n_cmp++; if (bus.op_o !== want) begin n_err++; $display("FAIL mid_after_op: got %h want %h", bus.op_o, want); end
    n_cmp++; if (bus.strb_o !== 4'b1111) begin n_err++; $display("FAIL mid_after_strb: got %b want 1111", bus.strb_o); end
    n_cmp++; if (bus.tag_o !== 4'd8) begin n_err++; $display("FAIL mid_after_tag: got %0d want 8", bus.tag_o); end
    cycle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_full_vector();
    test_partial();
    test_backpressure();
    test_flush();
    test_back_to_back_singles();
    test_reset_mid_fill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
